mod_reduce_pipe: RTL and testbench

Parametrised, pipelined reduction unit computing R = X mod MOD for a wide unsigned operand, using the input-splitting method. X is cut into K-bit chunks, each weighted by a constant 2^(K·i) mod MOD computed at elaboration, summed, folded, and corrected. It sits between operand producers and residue-number-system consumers. It carries a valid/ready handshake with backpressure and an opaque tag so results can be matched to requests.

---
 rtl/mod_reduce_if.sv | 23 ++
 rtl/mod_reduce_pipe.sv | 124 ++++++++++++
 tb/tb_mod_reduce_pipe.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mod_reduce_if.sv
// mod_reduce_if: request/response handshake bundle for mod_reduce_pipe
interface mod_reduce_if #(
    parameter int N_W = 100,
    parameter int K = 7,
    parameter int TAG_W = 4
);
    logic in_valid;
    logic in_ready;
    logic [N_W-1:0] in_x;
    logic [TAG_W-1:0] in_tag;
    logic out_valid;
    logic out_ready;
    logic [K-1:0] out_r;
    logic [TAG_W-1:0] out_tag;
    modport master (
        output in_valid, in_x, in_tag, out_ready,
        input in_ready, out_valid, out_r, out_tag
    );
    modport slave (
        input in_valid, in_x, in_tag, out_ready,
        output in_ready, out_valid, out_r, out_tag
    );
endinterface

// File: rtl/mod_reduce_pipe.sv
// mod_reduce_pipe: pipelined X mod MOD via weighted K-bit chunks, elaboration-sized folds and a final correction
module mod_reduce_pipe #(
    parameter int N_W = 100,
    parameter int MOD = 113,
    parameter int K = 7,
    parameter int TAG_W = 4
) (
    input logic clk,
    input logic rst,
    mod_reduce_if.slave bus
);
    localparam int C = (N_W + K - 1) / K;
    localparam longint MASK = (longint'(1) << K) - 1;
    localparam longint F = (longint'(1) << K) % MOD;
    localparam longint PMAX = longint'(C) * MASK * longint'(MOD - 1);
    localparam int P1W = $clog2(PMAX + 1);

    // exact worst case of one fold applied to any value <= m
    function automatic longint fold_bound(longint m);
        longint h = m >> K;
        longint top = h * F + (m & MASK);
        longint rest = (h - 1) * F + MASK;
        return (h == 0) ? m : ((top > rest) ? top : rest);
    endfunction

    function automatic longint bound_after(int j);
        longint m = PMAX;
        for (int i = 0; i < j; i++) m = fold_bound(m);
        return m;
    endfunction

    function automatic int count_folds();
        longint m = PMAX;
        int n = 0;
        for (int i = 0; i < 64; i++) begin
            if (m >= longint'(2 * MOD)) begin
                m = fold_bound(m);
                n++;
            end
        end
        return n;
    endfunction

    function automatic longint weight(int i);
        longint w = 1 % MOD;
        for (int t = 0; t < i; t++) w = (w * F) % MOD;
        return w;
    endfunction

    localparam int NF = count_folds();
    localparam int W2 = $clog2(bound_after(NF) + 1);

    if (MOD < 3 || MOD >= (1 << K) || MOD <= (1 << (K - 1))) begin : g_bad_mod
        $error("mod_reduce_pipe: MOD must satisfy 3 <= MOD and 2^(K-1) < MOD < 2^K");
    end

    logic en;
    logic v1;
    logic v2;
    logic [TAG_W-1:0] t1;
    logic [TAG_W-1:0] t2;
    logic [C*K-1:0] xp;
    logic [P1W-1:0] prod [C];
    logic [P1W-1:0] sum;
    logic [P1W-1:0] s1;
    logic [W2-1:0] s2;
    logic [K:0] s3x;
    logic [K-1:0] rdc;

    assign en = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = en;
    assign xp = (C*K)'(bus.in_x);

    for (genvar i = 0; i < C; i++) begin : g_chunk
        localparam longint WI = weight(i);
        assign prod[i] = P1W'(xp[K*i +: K]) * P1W'(WI);
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < C; i++) sum = sum + prod[i];
    end

    // each fold stage is sized to its own worst case so nothing can overflow
    for (genvar j = 0; j <= NF; j++) begin : f
        localparam int WJ = $clog2(bound_after(j) + 1);
        logic [WJ-1:0] v;
        if (j == 0) begin : g_in
            assign v = s1;
        end else begin : g_fold
            localparam int WP = $clog2(bound_after(j - 1) + 1);
            assign v = WJ'(f[j-1].v[K-1:0]) + WJ'(f[j-1].v[WP-1:K]) * WJ'(F);
        end
    end

    assign s3x = (K+1)'(s2);
    assign rdc = (s3x >= (K+1)'(MOD)) ? K'(s3x - (K+1)'(MOD)) : K'(s3x);

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            t1 <= '0;
            t2 <= '0;
            s1 <= '0;
            s2 <= '0;
            bus.out_valid <= 1'b0;
            bus.out_r <= '0;
            bus.out_tag <= '0;
        end else if (en) begin
            v1 <= bus.in_valid;
            t1 <= bus.in_tag;
            s1 <= sum;
            v2 <= v1;
            t2 <= t1;
            s2 <= f[NF].v;
            bus.out_valid <= v2;
            if (v2) begin
                bus.out_r <= rdc;
                bus.out_tag <= t2;
            end
        end
    end
endmodule

// File: tb/tb_mod_reduce_pipe.sv
// tb_mod_reduce_pipe: scoreboard bench for default, 64-bit/251 and 127 configurations
module tb_mod_reduce_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mod_reduce_if #(.N_W(100), .K(7), .TAG_W(4)) a ();
    mod_reduce_if #(.N_W(64), .K(8), .TAG_W(4)) b ();
    mod_reduce_if #(.N_W(100), .K(7), .TAG_W(4)) c ();

    mod_reduce_pipe #(.N_W(100), .MOD(113), .K(7), .TAG_W(4)) dut_a (.clk(clk), .rst(rst), .bus(a));
    mod_reduce_pipe #(.N_W(64), .MOD(251), .K(8), .TAG_W(4)) dut_b (.clk(clk), .rst(rst), .bus(b));
    mod_reduce_pipe #(.N_W(100), .MOD(127), .K(7), .TAG_W(4)) dut_c (.clk(clk), .rst(rst), .bus(c));

    // bit-serial golden modulo, independent of the chunking method
    function automatic int ref_mod(logic [127:0] x, int m);
        int r = 0;
        for (int i = 127; i >= 0; i--) r = (r * 2 + int'(x[i])) % m;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic v, input logic [127:0] x, input logic [3:0] t, input logic ordy);
        case (sel)
            0: begin a.in_valid = v; a.in_x = x[99:0]; a.in_tag = t; a.out_ready = ordy; end
            1: begin b.in_valid = v; b.in_x = x[63:0]; b.in_tag = t; b.out_ready = ordy; end
            default: begin c.in_valid = v; c.in_x = x[99:0]; c.in_tag = t; c.out_ready = ordy; end
        endcase
    endtask

    task automatic sample(input int sel, output logic ov, output logic ir, output int r, output logic [3:0] t);
        case (sel)
            0: begin ov = a.out_valid; ir = a.in_ready; r = int'(a.out_r); t = a.out_tag; end
            1: begin ov = b.out_valid; ir = b.in_ready; r = int'(b.out_r); t = b.out_tag; end
            default: begin ov = c.out_valid; ir = c.in_ready; r = int'(c.out_r); t = c.out_tag; end
        endcase
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) drive(s, 1'b1, '1, 4'hf, 1'b1);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int s = 0; s < 3; s++) drive(s, 1'b0, '0, '0, 1'b0);
        #1;
        total_cnt += 4;
        if (a.out_valid !== 1'b0) $display("FAIL reset out_valid: got %0b want 0", a.out_valid); else pass_cnt++;
        if (a.out_r !== 7'd0) $display("FAIL reset out_r: got %0d want 0", a.out_r); else pass_cnt++;
        if (a.out_tag !== 4'd0) $display("FAIL reset out_tag: got %0d want 0", a.out_tag); else pass_cnt++;
        if (a.in_ready !== 1'b1) $display("FAIL reset in_ready: got %0b want 1", a.in_ready); else pass_cnt++;
        for (int s = 0; s < 3; s++) drive(s, 1'b0, '0, '0, 1'b1);
        tick();
    endtask

    task automatic test_known_residues();
        logic [127:0] xs [6];
        int want [6];
        int qr[$];
        int qc[$];
        logic [3:0] qt[$];
        xs[0] = 128'd0;
        xs[1] = 128'd112;
        xs[2] = 128'd113;
        xs[3] = 128'd128;
        xs[4] = 128'd1 << 14;
        xs[5] = (128'd1 << 100) - 128'd1;
        want = '{0, 112, 0, 15, 112, 108};
        for (int cyc = 0; cyc < 12; cyc++) begin
            a.out_ready = 1'b1;
            a.in_tag = 4'(cyc);
            if (cyc < 6) begin
                a.in_valid = 1'b1;
                a.in_x = xs[cyc][99:0];
            end else begin
                a.in_valid = 1'b0;
                a.in_x = '0;
            end
            #1;
            if (a.out_valid) begin
                if (qr.size() == 0) begin
                    total_cnt++;
                    $display("FAIL known extra: got r=%0d tag=%0d want no output", a.out_r, a.out_tag);
                end else begin
                    int er;
                    int ec;
                    logic [3:0] et;
                    er = qr.pop_front();
                    ec = qc.pop_front();
                    et = qt.pop_front();
                    total_cnt += 3;
                    if (int'(a.out_r) !== er) $display("FAIL known r: got %0d want %0d", a.out_r, er); else pass_cnt++;
                    if (a.out_tag !== et) $display("FAIL known tag: got %0d want %0d", a.out_tag, et); else pass_cnt++;
                    if (cyc !== ec + 3) $display("FAIL known latency: got cycle %0d want %0d", cyc, ec + 3); else pass_cnt++;
                end
            end
            if (a.in_valid && a.in_ready) begin
                qr.push_back(want[cyc]);
                qc.push_back(cyc);
                qt.push_back(a.in_tag);
            end
            tick();
        end
        total_cnt++;
        if (qr.size() != 0) $display("FAIL known drain: got %0d pending want 0", qr.size()); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int qr[$];
        logic [3:0] qt[$];
        int hold_r;
        hold_r = ref_mod(128'd1000, 113);
        for (int cyc = 0; cyc < 14; cyc++) begin
            a.in_valid = (cyc < 8);
            a.in_x = 100'(1000 + 37 * cyc);
            a.in_tag = (cyc < 3) ? 4'(cyc + 1) : 4'd9;
            a.out_ready = !(cyc >= 3 && cyc < 8);
            #1;
            if (cyc >= 3 && cyc < 8) begin
                total_cnt += 4;
                if (a.in_ready !== 1'b0) $display("FAIL stall in_ready: got %0b want 0", a.in_ready); else pass_cnt++;
                if (a.out_valid !== 1'b1) $display("FAIL stall out_valid: got %0b want 1", a.out_valid); else pass_cnt++;
                if (a.out_tag !== 4'd1) $display("FAIL stall out_tag: got %0d want 1", a.out_tag); else pass_cnt++;
                if (int'(a.out_r) !== hold_r) $display("FAIL stall out_r: got %0d want %0d", a.out_r, hold_r); else pass_cnt++;
            end
            if (a.out_valid && a.out_ready) begin
                if (qr.size() == 0) begin
                    total_cnt++;
                    $display("FAIL bp extra: got tag=%0d want no output", a.out_tag);
                end else begin
                    int er;
                    logic [3:0] et;
                    er = qr.pop_front();
                    et = qt.pop_front();
                    total_cnt += 2;
                    if (int'(a.out_r) !== er) $display("FAIL bp r: got %0d want %0d", a.out_r, er); else pass_cnt++;
                    if (a.out_tag !== et) $display("FAIL bp tag: got %0d want %0d", a.out_tag, et); else pass_cnt++;
                end
            end
            if (a.in_valid && a.in_ready) begin
                qr.push_back(ref_mod(128'(a.in_x), 113));
                qt.push_back(a.in_tag);
            end
            tick();
        end
        total_cnt++;
        if (qr.size() != 0) $display("FAIL bp drain: got %0d pending want 0", qr.size()); else pass_cnt++;
    endtask

    task automatic test_bubbles();
        int qr[$];
        logic [3:0] qt[$];
        int wants [3];
        int last_r = 0;
        logic [3:0] last_t = '0;
        wants = '{87, 74, 61};
        for (int cyc = 0; cyc < 10; cyc++) begin
            a.out_ready = 1'b1;
            a.in_valid = (cyc < 5) && (cyc % 2 == 0);
            a.in_x = a.in_valid ? 100'(200 + 100 * (cyc / 2)) : 100'($urandom());
            a.in_tag = 4'(cyc / 2 + 1);
            #1;
            if (cyc >= 3 && cyc <= 7) begin
                total_cnt++;
                if (a.out_valid !== ((cyc - 3) % 2 == 0))
                    $display("FAIL bubble valid cycle %0d: got %0b want %0b", cyc, a.out_valid, (cyc - 3) % 2 == 0);
                else pass_cnt++;
            end
            if (a.out_valid) begin
                if (qr.size() == 0) begin
                    total_cnt++;
                    $display("FAIL bubble extra: got r=%0d want no output", a.out_r);
                end else begin
                    int er;
                    logic [3:0] et;
                    er = qr.pop_front();
                    et = qt.pop_front();
                    total_cnt += 2;
                    if (int'(a.out_r) !== er) $display("FAIL bubble r: got %0d want %0d", a.out_r, er); else pass_cnt++;
                    if (a.out_tag !== et) $display("FAIL bubble tag: got %0d want %0d", a.out_tag, et); else pass_cnt++;
                end
                last_r = int'(a.out_r);
                last_t = a.out_tag;
            end else if (cyc == 4 || cyc == 6) begin
                total_cnt += 2;
                if (int'(a.out_r) !== last_r) $display("FAIL bubble hold r: got %0d want %0d", a.out_r, last_r); else pass_cnt++;
                if (a.out_tag !== last_t) $display("FAIL bubble hold tag: got %0d want %0d", a.out_tag, last_t); else pass_cnt++;
            end
            if (a.in_valid && a.in_ready) begin
                qr.push_back(wants[cyc / 2]);
                qt.push_back(a.in_tag);
            end
            tick();
        end
        total_cnt++;
        if (qr.size() != 0) $display("FAIL bubble drain: got %0d pending want 0", qr.size()); else pass_cnt++;
    endtask

    task automatic test_reset_midflight();
        for (int cyc = 0; cyc < 2; cyc++) begin
            drive(0, 1'b1, {$urandom(), $urandom(), $urandom(), $urandom()}, 4'(5 + cyc), 1'b1);
            tick();
        end
        rst = 1'b1;
        drive(0, 1'b1, 128'd555, 4'd7, 1'b1);
        tick();
        rst = 1'b0;
        drive(0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            total_cnt++;
            if (a.out_valid !== 1'b0) $display("FAIL midreset valid cycle %0d: got %0b want 0", i, a.out_valid); else pass_cnt++;
            if (i == 0) begin
                total_cnt += 3;
                if (a.out_r !== 7'd0) $display("FAIL midreset out_r: got %0d want 0", a.out_r); else pass_cnt++;
                if (a.out_tag !== 4'd0) $display("FAIL midreset out_tag: got %0d want 0", a.out_tag); else pass_cnt++;
                if (a.in_ready !== 1'b1) $display("FAIL midreset in_ready: got %0b want 1", a.in_ready); else pass_cnt++;
            end
            tick();
        end
        drive(0, 1'b0, '0, '0, 1'b1);
    endtask

    task automatic run_random(input string name, input int sel, input int m, input int n, input logic [127:0] first);
        int qr[$];
        logic [3:0] qt[$];
        int sent = 0;
        int cyc = 0;
        int r;
        int pr = 0;
        int er;
        logic v;
        logic ordy;
        logic ov;
        logic ir;
        logic pstall = 1'b0;
        logic [3:0] tg;
        logic [3:0] t;
        logic [3:0] pt = '0;
        logic [3:0] et;
        logic [127:0] x;
        while ((sent < n || qr.size() > 0) && cyc < 20 * n + 200) begin
            v = (sent < n) && ($urandom_range(0, 3) != 0);
            ordy = $urandom_range(0, 3) != 0;
            tg = 4'($urandom());
            x = (sent == 0) ? first : {$urandom(), $urandom(), $urandom(), $urandom()};
            if (sel == 1) x[127:64] = '0; else x[127:100] = '0;
            drive(sel, v, x, tg, ordy);
            #1;
            sample(sel, ov, ir, r, t);
            if (pstall) begin
                total_cnt++;
                if (ov !== 1'b1 || r !== pr || t !== pt)
                    $display("FAIL %s hold: got valid=%0b r=%0d tag=%0d want valid=1 r=%0d tag=%0d", name, ov, r, t, pr, pt);
                else pass_cnt++;
            end
            if (ov && ordy) begin
                if (qr.size() == 0) begin
                    total_cnt++;
                    $display("FAIL %s extra: got r=%0d tag=%0d want no output", name, r, t);
                end else begin
                    er = qr.pop_front();
                    et = qt.pop_front();
                    total_cnt += 2;
                    if (r !== er) $display("FAIL %s r: got %0d want %0d", name, r, er); else pass_cnt++;
                    if (t !== et) $display("FAIL %s tag: got %0d want %0d", name, t, et); else pass_cnt++;
                end
            end
            if (v && ir) begin
                qr.push_back(ref_mod(x, m));
                qt.push_back(tg);
                sent++;
            end
            pstall = ov && !ordy;
            pr = r;
            pt = t;
            tick();
            cyc++;
        end
        drive(sel, 1'b0, '0, '0, 1'b1);
        total_cnt++;
        if (sent != n || qr.size() != 0)
            $display("FAIL %s completion: got sent=%0d pending=%0d want sent=%0d pending=0", name, sent, qr.size(), n);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        run_random("random113", 0, 113, 300, {$urandom(), $urandom(), $urandom(), $urandom()});
    endtask

    task automatic test_reparam();
        run_random("reparam251", 1, 251, 10000, (128'd1 << 64) - 128'd1);
    endtask

    task automatic test_worst_widths();
        run_random("worst113", 0, 113, 50, (128'd1 << 100) - 128'd1);
        run_random("worst127", 2, 127, 50, (128'd1 << 100) - 128'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int s = 0; s < 3; s++) drive(s, 1'b0, '0, '0, 1'b1);
        tick();
        test_reset();
        test_known_residues();
        test_backpressure();
        test_bubbles();
        test_back_to_back();
        test_reset_midflight();
        test_reparam();
        test_worst_widths();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
